game_cmd_scheduler: RTL
=======================

Name: game_cmd_scheduler

Overview:
- Sits between the input front-ends (PS/2 keyboard decoder, debounced KEY buttons) and the Game datapath.
- Merges held key codes and button pulses into game commands, adding auto-repeat (DAS/ARR) and a level-dependent gravity timer.
- Issues at most one command per video frame to Game over a valid/ready handshake, using fixed-priority arbitration.

Parameters:
- GRAV_INIT, 48: gravity period in frames at level 0.
- GRAV_STEP, 4: frames removed from the gravity period per level.
- GRAV_MIN, 4: floor for the gravity period, in frames.
- DAS_FRAMES, 10: frames a movement key must be held before auto-repeat starts.
- ARR_FRAMES, 3: frames between repeats once auto-repeat has started.

Ports:
- i_clk  in  1  system clock (25 MHz domain)
- i_rst_n  in  1  asynchronous active-low reset
- i_frame  in  1  one-cycle pulse at start of each frame (vsync edge)
- i_run  in  1  game running; low = idle/abort
- i_key_code  in  8  current held PS/2 make code; 8'h00 = none
- i_btn_left  in  1  debounced press pulse
- i_btn_right  in  1  debounced press pulse
- i_btn_rot  in  1  debounced press pulse
- i_level  in  4  current game level
- o_cmd  out  3  command: NONE=0, LEFT=1, RIGHT=2, ROT=3, SOFT=4, DROP=5, GRAV=6
- o_cmd_valid  out  1  command valid
- i_cmd_ready  in  1  Game accepts the command
- o_grav_period  out  7  active gravity period, for debug/HEX display

Behaviour:
- Reset (async):
  - state=IDLE; all pending flags and counters cleared.
  - o_cmd=0, o_cmd_valid=0.
  - o_grav_period=GRAV_INIT.
- Key map:
  - 8'h6B=LEFT, 8'h74=RIGHT, 8'h75=ROT, 8'h72=SOFT, 8'h29=DROP.
  - Any other code counts as no key.
  - A "press" is a change of i_key_code to a mapped code, registered one cycle.
- Pending flags (one per command):
  - Set by a press, a button pulse, a repeat event or gravity expiry.
  - Multiple events on one flag merge; no counting.
  - A flag clears only when its command is accepted.
- Auto-repeat (LEFT, RIGHT, SOFT):
  - A press sets the flag immediately.
  - While the same code is held, a frame counter counts i_frame pulses.
  - At DAS_FRAMES the flag is set, then again every ARR_FRAMES.
  - The counter resets on any code change.
  - ROT and DROP are one-shot per press.
- Gravity:
  - period = max(GRAV_INIT - GRAV_STEP*i_level, GRAV_MIN), computed in 8 bits with saturation (no underflow wrap) and registered to o_grav_period.
  - The frame counter sets grav_pend when it reaches period-1, then reloads to 0.
  - Acceptance of SOFT or DROP also reloads the counter to 0.
  - A level change takes effect at the next reload.
- FSM:
  - IDLE: outputs low, counters held at 0. Go to WAIT when i_run=1.
  - WAIT: on i_frame, if any flag is pending, pick the winner by priority DROP > ROT > LEFT > RIGHT > SOFT > GRAV. Latch it to o_cmd, assert o_cmd_valid next cycle, go to ISSUE.
  - ISSUE:
    - o_cmd and o_cmd_valid are held stable until i_cmd_ready=1.
    - On the handshake cycle: clear the granted flag, o_cmd_valid=0, o_cmd=0 next cycle, go to WAIT.
    - i_frame pulses during ISSUE still advance the repeat and gravity counters; no second issue happens in that frame.
- Boundaries:
  - i_run falling in any state: return to IDLE next cycle, drop o_cmd_valid without a handshake (the only permitted valid withdrawal), clear all flags.
  - Button pulse and key press for the same command in one cycle: single pending set.
  - i_frame coincident with the handshake cycle: arbitration waits for the next frame.
  - LEFT and RIGHT both pending: LEFT wins; RIGHT remains pending.

Decomposition:
- Shared package game_pkg:
  - cmd_t enum (3-bit).
  - Scan-code localparams.
  - Priority order constant.
- Sub-module key_repeat: DAS/ARR counter with inputs held, frame and press, and output fire. Instantiated three times (LEFT, RIGHT, SOFT).

Test Plan:
- Reset mid-ISSUE (o_cmd_valid=1, cmd=ROT) -> o_cmd_valid=0 and o_cmd=0 immediately; after release, state IDLE, o_grav_period=48.
- i_run=1, i_level=0, no input, ready tied 1 -> exactly one GRAV command every 48 frames. i_level=15 -> 48-60 saturates, GRAV every 4 frames.
- Hold 8'h6B for 20 frames, ready=1 -> LEFT issued at frame 0, then frames 10, 13, 16, 19; nothing else.
- Same cycle: i_btn_rot pulse and key 8'h29 press -> DROP issued first frame, ROT next frame, gravity counter reloaded after DROP.
- ready held 0 for 5 frames with LEFT issued -> o_cmd=LEFT and valid stable throughout; after accept, any pending GRAV issues on the following frame.
- i_run drops while valid=1, ready=0 -> valid low next cycle, all flags cleared; re-raising i_run with no input yields no command until the first gravity expiry.

Source files
------------

// File: rtl/game_pkg.sv
// Shared command encoding, PS/2 scan codes and arbitration order for the game command path.
// Pure definitions; no state, no latency.
package game_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_ROT   = 3'd3,
    CMD_SOFT  = 3'd4,
    CMD_DROP  = 3'd5,
    CMD_GRAV  = 3'd6
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ROT   = 8'h75;
  localparam logic [7:0] KEY_SOFT  = 8'h72;
  localparam logic [7:0] KEY_DROP  = 8'h29;

  // Slot 0 (LSBs) is the highest priority.
  localparam int         NUM_PRIO   = 6;
  localparam logic [17:0] PRIO_ORDER = {CMD_GRAV, CMD_SOFT, CMD_RIGHT, CMD_LEFT, CMD_ROT, CMD_DROP};

  function automatic cmd_t key_to_cmd(input logic [7:0] code);
    cmd_t c;
    case (code)
      KEY_LEFT:  c = CMD_LEFT;
      KEY_RIGHT: c = CMD_RIGHT;
      KEY_ROT:   c = CMD_ROT;
      KEY_SOFT:  c = CMD_SOFT;
      KEY_DROP:  c = CMD_DROP;
      default:   c = CMD_NONE;
    endcase
    return c;
  endfunction

  function automatic cmd_t pick_winner(input logic [6:0] pend);
    cmd_t win;
    cmd_t c;
    win = CMD_NONE;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      c = cmd_t'(PRIO_ORDER[3*i +: 3]);
      if (pend[c]) win = c;
    end
    return win;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// DAS/ARR auto-repeat for one held key: fires after DAS_FRAMES frames, then every ARR_FRAMES.
// fire is combinational on the frame pulse; no backpressure, the caller merges fires into a flag.
module key_repeat #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic held,
  input  logic frame,
  input  logic press,
  output logic fire
);

  localparam int CW = $clog2(DAS_FRAMES + ARR_FRAMES + 1);

  logic [CW-1:0] cnt;
  logic          rep;
  logic [CW-1:0] limit;

  assign limit = rep ? CW'(ARR_FRAMES - 1) : CW'(DAS_FRAMES - 1);
  assign fire  = held & frame & ~press & (cnt == limit);

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
      rep <= 1'b0;
    end else if (!held || press) begin
      cnt <= '0;
      rep <= 1'b0;
    end else if (frame) begin
      if (cnt == limit) begin
        cnt <= '0;
        rep <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/game_cmd_scheduler.sv
// Merges key/button/repeat/gravity events into pending flags; issues one command per frame by fixed priority.
// Command valid one cycle after the winning frame pulse; held stable until i_cmd_ready, withdrawn only by i_run low.
module game_cmd_scheduler
  import game_pkg::*;
#(
  parameter int GRAV_INIT  = 48,
  parameter int GRAV_STEP  = 4,
  parameter int GRAV_MIN   = 4,
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame,
  input  logic       i_run,
  input  logic [7:0] i_key_code,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_rot,
  input  logic [3:0] i_level,
  output logic [2:0] o_cmd,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic [6:0] o_grav_period
);

  localparam logic [6:0] PEND_MASK = 7'b1111110;

  state_t     state;
  cmd_t       cmd_q;
  logic       valid_q;
  logic [6:0] pend;
  logic [6:0] grav_cnt;
  logic [6:0] period_q;
  logic [7:0] key_q;

  cmd_t       key_cmd;
  logic       press;
  logic       fire_l, fire_r, fire_s;
  logic       accept;
  logic       grav_fire;
  logic [6:0] set_vec, clr_vec;
  logic [7:0] grav_prod, grav_diff, grav_calc;
  logic [6:0] grav_per7;

  assign key_cmd   = key_to_cmd(i_key_code);
  assign press     = (i_key_code != key_q) && (key_cmd != CMD_NONE);
  assign accept    = (state == ST_ISSUE) && i_cmd_ready;
  assign grav_fire = i_frame && (grav_cnt == period_q - 7'd1);

  key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_rep_left (
    .core_clk(i_clk), .arst_n(i_rst_n), .held(i_run && (i_key_code == KEY_LEFT)),
    .frame(i_frame), .press(press), .fire(fire_l));
  key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_rep_right (
    .core_clk(i_clk), .arst_n(i_rst_n), .held(i_run && (i_key_code == KEY_RIGHT)),
    .frame(i_frame), .press(press), .fire(fire_r));
  key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_rep_soft (
    .core_clk(i_clk), .arst_n(i_rst_n), .held(i_run && (i_key_code == KEY_SOFT)),
    .frame(i_frame), .press(press), .fire(fire_s));

  // Saturating period math in 8 bits so high levels clamp instead of wrapping.
  always_comb begin
    grav_prod = 8'(GRAV_STEP) * {4'd0, i_level};
    grav_diff = (8'(GRAV_INIT) > grav_prod) ? 8'(GRAV_INIT) - grav_prod : 8'd0;
    grav_calc = (grav_diff > 8'(GRAV_MIN)) ? grav_diff : 8'(GRAV_MIN);
    grav_per7 = grav_calc[7] ? 7'h7F : grav_calc[6:0];
  end

  always_comb begin
    set_vec = '0;
    if (press) set_vec[key_cmd] = 1'b1;
    set_vec[CMD_LEFT]  = set_vec[CMD_LEFT]  | i_btn_left  | fire_l;
    set_vec[CMD_RIGHT] = set_vec[CMD_RIGHT] | i_btn_right | fire_r;
    set_vec[CMD_ROT]   = set_vec[CMD_ROT]   | i_btn_rot;
    set_vec[CMD_SOFT]  = set_vec[CMD_SOFT]  | fire_s;
    set_vec[CMD_GRAV]  = grav_fire;
    clr_vec = '0;
    if (accept) clr_vec[cmd_q] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cmd_q    <= CMD_NONE;
      valid_q  <= 1'b0;
      pend     <= '0;
      grav_cnt <= '0;
      period_q <= 7'(GRAV_INIT);
      key_q    <= '0;
    end else begin
      key_q <= i_key_code;
      if (!i_run || state == ST_IDLE) begin
        // Idle keeps the gravity counter in reload so the level is picked up continuously.
        pend     <= '0;
        grav_cnt <= '0;
        period_q <= grav_per7;
        cmd_q    <= CMD_NONE;
        valid_q  <= 1'b0;
        state    <= i_run ? ST_WAIT : ST_IDLE;
      end else begin
        pend <= ((pend & ~clr_vec) | set_vec) & PEND_MASK;
        if (grav_fire || (accept && (cmd_q == CMD_SOFT || cmd_q == CMD_DROP))) begin
          grav_cnt <= '0;
          period_q <= grav_per7;
        end else if (i_frame) begin
          grav_cnt <= grav_cnt + 7'd1;
        end
        case (state)
          ST_WAIT: begin
            if (i_frame && |pend) begin
              cmd_q   <= pick_winner(pend);
              valid_q <= 1'b1;
              state   <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (i_cmd_ready) begin
              cmd_q   <= CMD_NONE;
              valid_q <= 1'b0;
              state   <= ST_WAIT;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_cmd         = cmd_q;
  assign o_cmd_valid   = valid_q;
  assign o_grav_period = period_q;

endmodule
